// File: rtl/dividend_reconstructor.sv
`default_nettype none
// ============================================================================
// Module   : dividend_reconstructor
// Purpose  : Rebuilds N = Q*D + R from an unsigned restoring divider's outputs
//            using an MSB-first shift-and-add walk over Q, then adds R.
// Revision : 1.0
// ============================================================================
module dividend_reconstructor #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     D,
    input  logic [WIDTH-1:0]     R,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   N_out,
    output logic                 overflow,
    output logic                 rem_err
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SHIFT_ADD = 2'd1,
        S_ADD_REM   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_d;
    logic [WIDTH-1:0]     r_r;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_i;
    logic [2*WIDTH-1:0]   r_n;
    logic                 r_ovf;
    logic                 r_rem_err;

    logic                 w_last;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;

    assign w_last = (r_i == c_LAST);

    // r_q is shifted left each step, so its MSB is always the current quotient bit.
    assign w_addend = r_q[WIDTH-1] ? {{WIDTH{1'b0}}, r_d} : '0;
    assign w_sum    = r_acc + {{WIDTH{1'b0}}, r_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = S_SHIFT_ADD;
                end
            end
            S_SHIFT_ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_ADD_REM;
                end
            end
            S_ADD_REM: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_d       <= '0;
            r_r       <= '0;
            r_acc     <= '0;
            r_i       <= '0;
            r_n       <= '0;
            r_ovf     <= 1'b0;
            r_rem_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q   <= Q;
                        r_d   <= D;
                        r_r   <= R;
                        r_acc <= '0;
                        r_i   <= '0;
                    end
                end
                S_SHIFT_ADD: begin
                    r_acc <= (r_acc << 1) + w_addend;
                    r_q   <= r_q << 1;
                    r_i   <= r_i + c_ONE;
                end
                S_ADD_REM: begin
                    r_n       <= w_sum;
                    r_ovf     <= |w_sum[2*WIDTH-1:WIDTH];
                    // D == 0 is caught here too, since any R >= 0.
                    r_rem_err <= (r_r >= r_d);
                end
                default: begin
                end
            endcase
        end
    end

    assign N_out    = r_n;
    assign overflow = r_ovf;
    assign rem_err  = r_rem_err;

endmodule
`default_nettype wire
